// File: rtl/buzzer_pkg.sv
// Shared state encodings and beep-pattern table for the buzzer sequencer.
// Each pattern is defined by (beeps, on units, gap units).
package buzzer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic [2:0] pat_beeps(input logic [1:0] sel);
        logic [2:0] v;
        case (sel)
            2'd0:    v = 3'd1;
            2'd1:    v = 3'd2;
            2'd2:    v = 3'd3;
            default: v = 3'd4;
        endcase
        return v;
    endfunction

    function automatic logic [2:0] pat_on_units(input logic [1:0] sel);
        logic [2:0] v;
        case (sel)
            2'd0:    v = 3'd2;
            2'd1:    v = 3'd1;
            2'd2:    v = 3'd1;
            default: v = 3'd4;
        endcase
        return v;
    endfunction

    function automatic logic [2:0] pat_gap_units(input logic [1:0] sel);
        logic [2:0] v;
        case (sel)
            2'd0:    v = 3'd0;
            2'd1:    v = 3'd1;
            2'd2:    v = 3'd1;
            default: v = 3'd4;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/unit_timer.sv
// Counts units*UNIT_CYCLES clock cycles after a load and pulses expire on the
// last cycle of the interval; the counter saturates instead of wrapping.
module unit_timer #(
    parameter int unsigned UNIT_CYCLES = 5000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [2:0] units,
    output logic       expire
);

    localparam int unsigned CW = $clog2(4 * UNIT_CYCLES + 1);

    logic [CW-1:0] count;
    logic [CW-1:0] target;

    assign target = CW'(units) * CW'(UNIT_CYCLES);

    always_comb begin
        expire = 1'b0;
        if (target == '0) begin
            expire = 1'b1;
        end else if (count == target - CW'(1)) begin
            expire = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (count != '1) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/buzzer_sequencer.sv
// Plays one of four beep patterns on an active buzzer: ON/GAP intervals timed
// by unit_timer, with abort via stop and a one-cycle done pulse on completion.
module buzzer_sequencer
    import buzzer_pkg::*;
#(
    parameter int unsigned UNIT_CYCLES = 5000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] pattern,
    input  logic       stop,
    output logic       buzzer,
    output logic       busy,
    output logic       done
);

    state_t     state, state_next;
    logic [1:0] pat_q;
    logic [2:0] beep_cnt;
    logic [2:0] units;
    logic       accept;
    logic       load;
    logic       expire;

    assign accept = (state == IDLE) && start && !stop;

    unit_timer #(
        .UNIT_CYCLES(UNIT_CYCLES)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .units (units),
        .expire(expire)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The timer restarts from zero on every state change, so each ON/GAP
    // interval is measured from its own first cycle.
    always_comb begin
        state_next = state;
        buzzer     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        units      = (state == GAP) ? pat_gap_units(pat_q) : pat_on_units(pat_q);
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = ON;
                end
            end
            ON: begin
                buzzer = 1'b1;
                busy   = 1'b1;
                if (stop) begin
                    state_next = IDLE;
                end else if (expire) begin
                    state_next = (beep_cnt > 3'd1) ? GAP : DONE;
                end
            end
            GAP: begin
                busy = 1'b1;
                if (stop) begin
                    state_next = IDLE;
                end else if (expire) begin
                    state_next = ON;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        load = (state_next != state);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_q    <= '0;
            beep_cnt <= '0;
        end else if (accept) begin
            pat_q    <= pattern;
            beep_cnt <= pat_beeps(pattern);
        end else if (state == GAP && !stop && expire && beep_cnt != '0) begin
            beep_cnt <= beep_cnt - 3'd1;
        end
    end

endmodule

// File: tb/tb_buzzer_sequencer.sv
// Directed bench for buzzer_sequencer with UNIT_CYCLES=4: expected
// {buzzer,busy,done} samples are queued from a pattern-table model and checked each cycle.
module tb_buzzer_sequencer;

    localparam int UNIT = 4;
    localparam int BEEPS [4] = '{1, 2, 3, 4};
    localparam int ON_U  [4] = '{2, 1, 1, 4};
    localparam int GAP_U [4] = '{0, 1, 1, 4};

    logic       clk;
    logic       rst;
    logic       start;
    logic [1:0] pattern;
    logic       stop;
    logic       buzzer;
    logic       busy;
    logic       done;

    logic [2:0] exp_q [$];
    int         n_vec;
    int         n_err;

    buzzer_sequencer #(
        .UNIT_CYCLES(UNIT)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .pattern(pattern),
        .stop   (stop),
        .buzzer (buzzer),
        .busy   (busy),
        .done   (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(3'b000);
    endtask

    task automatic push_pattern(input int p, input int limit);
        logic [2:0] tr [$];
        for (int b = 0; b < BEEPS[p]; b++) begin
            for (int i = 0; i < ON_U[p] * UNIT; i++) tr.push_back(3'b110);
            if (b < BEEPS[p] - 1) begin
                for (int i = 0; i < GAP_U[p] * UNIT; i++) tr.push_back(3'b010);
            end
        end
        tr.push_back(3'b001);
        for (int i = 0; i < tr.size() && i < limit; i++) exp_q.push_back(tr[i]);
    endtask

    task automatic check(input string tag);
        logic [2:0] obs;
        logic [2:0] exp;
        obs = {buzzer, busy, done};
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $error("FAIL %s: no expected sample queued, obs=%b", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            assert (obs === exp)
            else begin
                n_err++;
                $error("FAIL %s: {buzzer,busy,done} obs=%b exp=%b", tag, obs, exp);
            end
        end
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check(tag);
        end
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        rst     = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        pattern = 2'd0;

        #2;
        push_idle(1);
        check("reset_state");
        push_idle(2);
        run(2, "reset_hold");

        // first start accepted on the first edge after release
        @(negedge clk);
        rst     = 1'b1;
        start   = 1'b1;
        pattern = 2'd0;
        push_pattern(0, 100);
        push_idle(1);
        run(1, "pat0");
        start = 1'b0;
        run(9, "pat0");

        start   = 1'b1;
        pattern = 2'd1;
        push_pattern(1, 100);
        push_idle(1);
        run(1, "pat1");
        start = 1'b0;
        run(13, "pat1");

        start   = 1'b1;
        pattern = 2'd2;
        push_pattern(2, 100);
        push_idle(1);
        run(1, "pat2");
        start = 1'b0;
        run(21, "pat2");

        // pattern 3 aborted by stop during cycle 20
        start   = 1'b1;
        pattern = 2'd3;
        push_pattern(3, 20);
        push_idle(3);
        run(1, "pat3_stop");
        start = 1'b0;
        run(19, "pat3_stop");
        stop = 1'b1;
        run(1, "pat3_stop");
        stop = 1'b0;
        run(2, "pat3_stop");

        start   = 1'b1;
        stop    = 1'b1;
        pattern = 2'd2;
        push_idle(3);
        run(3, "start_stop_idle");
        start = 1'b0;
        stop  = 1'b0;

        // pattern 2 interrupted by reset at cycle 6, then a fresh pattern 0
        start   = 1'b1;
        pattern = 2'd2;
        push_pattern(2, 6);
        run(1, "pat2_rst");
        start = 1'b0;
        run(5, "pat2_rst");
        #2;
        rst = 1'b0;
        #1;
        push_idle(1);
        check("async_rst");
        @(negedge clk);
        rst     = 1'b1;
        start   = 1'b1;
        pattern = 2'd0;
        push_pattern(0, 100);
        push_idle(1);
        run(1, "pat0_after_rst");
        start = 1'b0;
        run(9, "pat0_after_rst");

        // start held through DONE re-triggers on the first IDLE cycle
        start   = 1'b1;
        pattern = 2'd0;
        push_pattern(0, 100);
        push_idle(1);
        push_pattern(0, 100);
        push_idle(1);
        run(11, "start_held");
        start = 1'b0;
        run(9, "start_held");

        // start/pattern changes during a pattern-1 run are ignored
        start   = 1'b1;
        pattern = 2'd1;
        push_pattern(1, 100);
        push_idle(1);
        run(1, "pat1_restart");
        start = 1'b0;
        run(4, "pat1_restart");
        start   = 1'b1;
        pattern = 2'd3;
        run(1, "pat1_restart");
        start = 1'b0;
        run(8, "pat1_restart");

        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $error("FAIL leftover: %0d expected samples never compared, exp=0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
